// File: rtl/csc_pkg.sv
// csc_pkg: shared state/slot types, complex-word struct and width helpers
// for the CSC tridiagonal generator.
package csc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef enum logic [1:0] {SLOT_A1, SLOT_S, SLOT_A0} slot_t;
    localparam int CPLX_DW = 32;
    typedef struct packed {
        logic [CPLX_DW-1:0] re;
        logic [CPLX_DW-1:0] im;
    } cplx_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int ptr_w(input int n);
        return $clog2(3 * n + 1);
    endfunction
endpackage

// File: rtl/csc_col_seq.sv
// csc_col_seq: maps (column, slot) to the row index, coefficient select and
// column/matrix end flags of the tridiagonal CSC stream.
module csc_col_seq
    import csc_pkg::*;
#(
    parameter int MAT_RANK = 256,
    localparam int IW = idx_w(MAT_RANK)
) (
    input  logic [IW-1:0] col,
    input  logic [1:0]    slot,
    input  logic          cyclic,
    output logic [IW-1:0] row,
    output slot_t         sel,
    output logic          last,
    output logic          eom
);
    localparam logic [IW-1:0] ROW_MAX = IW'(MAT_RANK - 1);
    localparam logic [IW-1:0] ROW_PEN = IW'(MAT_RANK - 2);
    logic first_col, last_col;
    assign first_col = col == '0;
    assign last_col = col == ROW_MAX;
    always_comb begin
        if (first_col) begin
            row = slot == 2'd0 ? '0 : slot == 2'd1 ? IW'(1) : ROW_MAX;
            sel = slot == 2'd0 ? SLOT_S : slot == 2'd1 ? SLOT_A0 : SLOT_A1;
        end else if (last_col && cyclic) begin
            // the wrapped sub-diagonal entry lands on row 0, so it leads the column
            row = slot == 2'd0 ? '0 : slot == 2'd1 ? ROW_PEN : ROW_MAX;
            sel = slot == 2'd0 ? SLOT_A0 : slot == 2'd1 ? SLOT_A1 : SLOT_S;
        end else begin
            row = slot == 2'd0 ? col - IW'(1) : slot == 2'd1 ? col : col + IW'(1);
            sel = slot == 2'd0 ? SLOT_A1 : slot == 2'd1 ? SLOT_S : SLOT_A0;
        end
    end
    assign last = (cyclic || !(first_col || last_col)) ? slot == 2'd2 : slot == 2'd1;
    assign eom = last_col && last;
endmodule

// File: rtl/csc_tridiag_gen.sv
// csc_tridiag_gen: streams the nonzeros of a complex tridiagonal matrix in CSC
// order with a column-pointer sideband; optional periodic corner entries.
module csc_tridiag_gen
    import csc_pkg::*;
#(
    parameter int MAT_RANK = 256,
    parameter int DW = 32,
    localparam int IW = idx_w(MAT_RANK),
    localparam int PW = ptr_w(MAT_RANK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          cfg_vld,
    output logic          cfg_rdy,
    input  logic          cfg_cyclic,
    input  logic [DW-1:0] s_val_r,
    input  logic [DW-1:0] s_val_i,
    input  logic [DW-1:0] a0_val_r,
    input  logic [DW-1:0] a0_val_i,
    input  logic [DW-1:0] a1_val_r,
    input  logic [DW-1:0] a1_val_i,
    output logic          ent_vld,
    input  logic          ent_rdy,
    output logic [IW-1:0] ent_row,
    output logic [IW-1:0] ent_col,
    output logic [DW-1:0] ent_val_r,
    output logic [DW-1:0] ent_val_i,
    output logic [PW-1:0] ent_idx,
    output logic          ent_last,
    output logic          ent_eom,
    output logic          ptr_vld,
    output logic [PW-1:0] col_ptr,
    output logic          busy,
    output logic          done
);
    state_t state;
    logic [IW-1:0] col, row;
    logic [1:0] slot;
    logic [PW-1:0] idx;
    logic cyclic, run, accept, last, eom;
    logic [DW-1:0] s_r, s_i, a0_r, a0_i, a1_r, a1_i;
    slot_t sel;
    csc_col_seq #(.MAT_RANK(MAT_RANK)) u_seq (
        .col(col),
        .slot(slot),
        .cyclic(cyclic),
        .row(row),
        .sel(sel),
        .last(last),
        .eom(eom)
    );
    assign run = state == RUN;
    assign accept = run && ent_rdy && !clr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col <= '0;
            slot <= '0;
            idx <= '0;
        end else if (clr) begin
            state <= IDLE;
            col <= '0;
            slot <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: if (cfg_vld) state <= RUN;
                RUN: if (ent_rdy) begin
                    idx <= idx + PW'(1);
                    slot <= last ? 2'd0 : slot + 2'd1;
                    col <= eom ? '0 : last ? col + IW'(1) : col;
                    if (eom) state <= FLUSH;
                end
                FLUSH: begin
                    state <= IDLE;
                    idx <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // coefficients and mode stay frozen from capture until the next IDLE handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyclic <= 1'b0;
            {s_r, s_i, a0_r, a0_i, a1_r, a1_i} <= '0;
        end else if (cfg_rdy && cfg_vld && !clr) begin
            cyclic <= cfg_cyclic;
            {s_r, s_i, a0_r, a0_i, a1_r, a1_i} <= {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i};
        end
    end
    assign cfg_rdy = state == IDLE;
    assign busy = !cfg_rdy;
    assign done = state == FLUSH;
    assign ent_vld = run;
    assign ent_row = run ? row : '0;
    assign ent_col = run ? col : '0;
    assign ent_val_r = !run ? '0 : sel == SLOT_S ? s_r : sel == SLOT_A0 ? a0_r : a1_r;
    assign ent_val_i = !run ? '0 : sel == SLOT_S ? s_i : sel == SLOT_A0 ? a0_i : a1_i;
    assign ent_idx = run ? idx : '0;
    assign ent_last = run && last;
    assign ent_eom = run && eom;
    assign ptr_vld = done || (accept && slot == 2'd0);
    assign col_ptr = ptr_vld ? idx : '0;
endmodule

// File: tb/tb_csc_tridiag_gen.sv
// tb_csc_tridiag_gen: directed + randomized checks of the CSC tridiagonal
// stream against a row/column reference model.
module tb_csc_tridiag_gen;
    localparam int N = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int PW = 4;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, cfg_vld = 1'b0, cfg_cyclic = 1'b0, ent_rdy = 1'b0;
    logic [DW-1:0] s_val_r = '0, s_val_i = '0, a0_val_r = '0, a0_val_i = '0, a1_val_r = '0, a1_val_i = '0;
    logic cfg_rdy, ent_vld, ent_last, ent_eom, ptr_vld, busy, done;
    logic [IW-1:0] ent_row, ent_col;
    logic [DW-1:0] ent_val_r, ent_val_i;
    logic [PW-1:0] ent_idx, col_ptr;
    int errors = 0, checks = 0;
    typedef struct {
        int row;
        int col;
        logic [DW-1:0] vr;
        logic [DW-1:0] vi;
        bit first;
        bit last;
        bit eom;
    } ent_t;
    ent_t exp_q[$];
    int ptr_log[$];
    logic [DW-1:0] m_s_r, m_s_i, m_a0_r, m_a0_i, m_a1_r, m_a1_i;
    logic [DW-1:0] alt_s_r, alt_s_i, alt_a0_r, alt_a0_i, alt_a1_r, alt_a1_i;
    int exp_open[5] = '{0, 2, 5, 8, 10};
    int exp_cyc[5] = '{0, 3, 6, 9, 12};

    csc_tridiag_gen #(.MAT_RANK(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
        .cfg_cyclic(cfg_cyclic), .s_val_r(s_val_r), .s_val_i(s_val_i),
        .a0_val_r(a0_val_r), .a0_val_i(a0_val_i), .a1_val_r(a1_val_r), .a1_val_i(a1_val_i),
        .ent_vld(ent_vld), .ent_rdy(ent_rdy), .ent_row(ent_row), .ent_col(ent_col),
        .ent_val_r(ent_val_r), .ent_val_i(ent_val_i), .ent_idx(ent_idx),
        .ent_last(ent_last), .ent_eom(ent_eom), .ptr_vld(ptr_vld), .col_ptr(col_ptr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: a column holds every row within distance 1 (modulo N when cyclic).
    task automatic build(input bit cyc);
        ent_t e;
        int d, lastk;
        bit inc;
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) begin
                d = (r - c + N) % N;
                inc = cyc ? (d == 0 || d == 1 || d == N - 1) : (r - c >= -1 && r - c <= 1);
                if (inc) begin
                    e.row = r;
                    e.col = c;
                    e.vr = d == 0 ? m_s_r : d == 1 ? m_a0_r : m_a1_r;
                    e.vi = d == 0 ? m_s_i : d == 1 ? m_a0_i : m_a1_i;
                    e.first = exp_q.size() == 0 || exp_q[exp_q.size() - 1].col != c;
                    e.last = 1'b0;
                    e.eom = 1'b0;
                    exp_q.push_back(e);
                end
            end
            lastk = exp_q.size() - 1;
            e = exp_q[lastk];
            e.last = 1'b1;
            exp_q[lastk] = e;
        end
        e = exp_q[exp_q.size() - 1];
        e.eom = 1'b1;
        exp_q[exp_q.size() - 1] = e;
    endtask

    task automatic configure(input bit cyc);
        @(negedge clk);
        ent_rdy = 1'b0;
        #1;
        chk("cfg_rdy_idle", cfg_rdy, 1);
        cfg_vld = 1'b1;
        cfg_cyclic = cyc;
        {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i} = {m_s_r, m_s_i, m_a0_r, m_a0_i, m_a1_r, m_a1_i};
        @(posedge clk);
        #1;
        cfg_vld = 1'b0;
        cfg_cyclic = ~cyc;
        {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run(input int duty, input bit cyc, input int cfg_at, input int clr_at, input int rst_at);
        ent_t e;
        int k;
        bit fin, exp_p;
        build(cyc);
        ptr_log.delete();
        configure(cyc);
        k = 0;
        fin = 1'b0;
        for (int n = 0; n < 500 && !fin; n++) begin
            @(negedge clk);
            ent_rdy = $urandom_range(99) < duty;
            cfg_vld = 1'b0;
            if (n == cfg_at) begin
                cfg_vld = 1'b1;
                cfg_cyclic = ~cyc;
                {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i} = {alt_s_r, alt_s_i, alt_a0_r, alt_a0_i, alt_a1_r, alt_a1_i};
            end
            #1;
            if (n == cfg_at) chk("cfg_rdy_run", {cfg_rdy, busy}, 2'b01);
            if (ptr_vld) ptr_log.push_back(int'(col_ptr));
            if (done) begin
                chk("done_count", k, exp_q.size());
                chk("flush_out", {ent_vld, ptr_vld, col_ptr}, {1'b0, 1'b1, PW'(exp_q.size())});
                fin = 1'b1;
            end else if (k >= exp_q.size()) begin
                chk("overrun", k, exp_q.size() - 1);
                fin = 1'b1;
            end else begin
                chk("ent_vld", ent_vld, 1);
                e = exp_q[k];
                chk("entry", {ent_row, ent_col, ent_val_r, ent_val_i, ent_idx, ent_last, ent_eom},
                    {IW'(e.row), IW'(e.col), e.vr, e.vi, PW'(k), e.last, e.eom});
                exp_p = ent_rdy && e.first;
                chk("ptr_vld", ptr_vld, exp_p);
                if (exp_p) chk("col_ptr", col_ptr, k);
                if (k == clr_at) begin
                    clr = 1'b1;
                    @(negedge clk);
                    #1;
                    chk("after_clr", {ent_vld, busy, cfg_rdy, done, ptr_vld}, 5'b00100);
                    clr = 1'b0;
                    @(negedge clk);
                    #1;
                    chk("clr_no_done", {done, busy}, 2'b00);
                    return;
                end
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("async_rst", {ent_vld, busy, cfg_rdy, done, ptr_vld, ent_idx, ent_val_r, ent_val_i},
                        {5'b00100, PW'(0), DW'(0), DW'(0)});
                    @(negedge clk);
                    rst_n = 1'b1;
                    #1;
                    chk("rst_release", {cfg_rdy, busy, done, ent_vld}, 4'b1000);
                    return;
                end
                if (ent_rdy) k++;
            end
        end
        chk("done_seen", fin, 1);
        @(negedge clk);
        #1;
        chk("post_done", {done, busy, cfg_rdy, ent_vld, ptr_vld}, 5'b00100);
    endtask

    initial begin
        #3;
        chk("reset_state", {cfg_rdy, ent_vld, busy, done, ptr_vld, ent_eom, ent_last, ent_idx, col_ptr},
            {7'b1000000, PW'(0), PW'(0)});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        {m_s_r, m_s_i, m_a0_r, m_a0_i, m_a1_r, m_a1_i} = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        run(100, 1'b0, -1, -1, -1);
        chk("open_ptr_count", ptr_log.size(), 5);
        for (int i = 0; i < 5; i++) chk("open_ptr", ptr_log.size() > i ? ptr_log[i] : -1, exp_open[i]);
        run(100, 1'b1, -1, -1, -1);
        chk("cyc_ptr_count", ptr_log.size(), 5);
        for (int i = 0; i < 5; i++) chk("cyc_ptr", ptr_log.size() > i ? ptr_log[i] : -1, exp_cyc[i]);
        {m_s_r, m_s_i, m_a0_r, m_a0_i, m_a1_r, m_a1_i} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(30, 1'b0, -1, -1, -1);
        chk("stall_open_ptr", ptr_log.size(), 5);
        run(30, 1'b1, -1, -1, -1);
        chk("stall_cyc_ptr", ptr_log.size(), 5);
        {alt_s_r, alt_s_i, alt_a0_r, alt_a0_i, alt_a1_r, alt_a1_i} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run(100, 1'b0, 3, -1, -1);
        {m_s_r, m_s_i, m_a0_r, m_a0_i, m_a1_r, m_a1_i} = {alt_s_r, alt_s_i, alt_a0_r, alt_a0_i, alt_a1_r, alt_a1_i};
        run(60, 1'b1, -1, -1, -1);
        run(100, 1'b0, -1, 4, -1);
        run(100, 1'b1, -1, -1, -1);
        run(70, 1'b1, -1, -1, 5);
        run(100, 1'b0, -1, -1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
